if_id_stage: RTL and testbench

Fetch-to-decode pipeline stage between the instruction fetch unit and the execute stage. It accepts `{pc, instr}` pairs from fetch over a valid/ready handshake and buffers them in a 2-entry FIFO. At enqueue it pre-decodes RV32I register fields, instruction format and sign-extended immediate, so every decode output leaves a flop. It also handles branch-redirect flushes and halts the front end after an `ebreak` retires out of the stage.

---
 rtl/if_id_stage.sv | 99 +++++++++
 tb/tb_if_id_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: 2-entry fetch-to-decode FIFO with RV32I pre-decode at enqueue, flush and ebreak halt.
module if_id_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [WIDTH-1:0] out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic             out_ebreak,
  output logic             halted
);
  logic [6:0]       w_op;
  logic             w_i, w_s, w_b, w_u, w_j, w_r;
  logic [2:0]       w_fmt;
  logic [WIDTH-1:0] w_imm;
  logic             w_illegal, w_ebreak, w_push, w_pop;
  logic             r_wp, r_rp, r_halted;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_pc [DEPTH];
  logic [WIDTH-1:0] r_instr [DEPTH];
  logic [WIDTH-1:0] r_imm [DEPTH];
  logic [2:0]       r_fmt [DEPTH];
  logic             r_illegal [DEPTH];
  logic             r_ebreak [DEPTH];

  assign w_op = in_instr[6:0];
  assign w_i = w_op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011};
  assign w_s = w_op == 7'b0100011;
  assign w_b = w_op == 7'b1100011;
  assign w_u = w_op inside {7'b0110111, 7'b0010111};
  assign w_j = w_op == 7'b1101111;
  assign w_r = w_op == 7'b0110011;
  assign w_fmt = w_r ? 3'd0 : w_i ? 3'd1 : w_s ? 3'd2 : w_b ? 3'd3 : w_u ? 3'd4 : w_j ? 3'd5 : 3'd7;
  assign w_imm = w_i ? {{20{in_instr[31]}}, in_instr[31:20]} :
                 w_s ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                 w_b ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                 w_u ? {in_instr[31:12], 12'b0} :
                 w_j ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                 '0;
  assign w_illegal = (w_fmt == 3'd7) || (in_instr[1:0] != 2'b11);
  assign w_ebreak = in_instr == 32'h0010_0073;

  assign in_ready  = (r_count != 2'd2) && !r_halted;
  assign out_valid = r_count != 2'd0;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready;
  assign halted    = r_halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_count  <= 2'd0;
      r_halted <= 1'b0;
    end else begin
      r_wp    <= flush ? 1'b0 : r_wp ^ w_push;
      r_rp    <= flush ? 1'b0 : r_rp ^ w_pop;
      r_count <= flush ? 2'd0 : r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop && out_ebreak)
        r_halted <= 1'b1;
    end
  end

  // Payload needs no reset: the read side is gated by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wp]      <= in_pc;
      r_instr[r_wp]   <= in_instr;
      r_imm[r_wp]     <= w_imm;
      r_fmt[r_wp]     <= w_fmt;
      r_illegal[r_wp] <= w_illegal;
      r_ebreak[r_wp]  <= w_ebreak;
    end
  end

  assign out_pc      = out_valid ? r_pc[r_rp] : '0;
  assign out_instr   = out_valid ? r_instr[r_rp] : '0;
  assign out_rd      = out_instr[11:7];
  assign out_rs1     = out_instr[19:15];
  assign out_rs2     = out_instr[24:20];
  assign out_imm     = out_valid ? r_imm[r_rp] : '0;
  assign out_fmt     = out_valid ? r_fmt[r_rp] : 3'd0;
  assign out_illegal = out_valid && r_illegal[r_rp];
  assign out_ebreak  = out_valid && r_ebreak[r_rp];
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed and randomized checks of if_id_stage against a queue-based reference model.
module tb_if_id_stage;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic        out_illegal, out_ebreak, halted;
  logic [31:0] in_pc, in_instr, out_pc, out_instr, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_fmt;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  bit   m_halted = 0;

  if_id_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .out_ebreak(out_ebreak), .halted(halted)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_fmt(logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      7'h33:                      return 3'd0;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(logic [31:0] i);
    int v;
    case (ref_fmt(i))
      3'd1: begin v = i[31:20]; v -= i[31] ? 4096 : 0; end
      3'd2: begin v = i[31:25] * 32 + i[11:7]; v -= i[31] ? 4096 : 0; end
      3'd3: begin v = i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2; v -= i[31] ? 4096 : 0; end
      3'd4: v = i & 32'hFFFF_F000;
      3'd5: begin v = i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2; v -= i[31] ? (1 << 20) : 0; end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic cycle();
    bit push, pop;
    push = in_valid && q.size() < 2 && !m_halted && !flush;
    pop  = out_ready && q.size() != 0;
    @(posedge clk);
    if (pop) begin
      if (q[0].instr == EBREAK) m_halted = 1;
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (push) q.push_back('{in_pc, in_instr});
    #1;
  endtask

  task automatic do_reset();
    rst = 0; in_valid = 0; flush = 0; out_ready = 0; in_pc = 0; in_instr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    q.delete();
    m_halted = 0;
  endtask

  task automatic test_reset();
    rst = 0; in_valid = 0; flush = 0; out_ready = 1; in_pc = 32'h1234; in_instr = 32'h13;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++;
    if ({out_pc, out_instr, out_imm, out_rd, out_rs1, out_rs2, out_fmt, out_illegal, out_ebreak} !== '0) begin
      errors++; $display("FAIL reset_data pc=%h instr=%h imm=%h fmt=%0d want all 0", out_pc, out_instr, out_imm, out_fmt);
    end
    do_reset();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1; in_valid = 1; in_pc = 32'h8000_0000; in_instr = 32'h0050_0093;
    cycle();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (out_fmt !== 3'd1) begin errors++; $display("FAIL single_fmt got %0d want 1", out_fmt); end
    checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin errors++; $display("FAIL single_regs rd=%0d rs1=%0d want 1/0", out_rd, out_rs1); end
    checks++; if (out_imm !== 32'h5) begin errors++; $display("FAIL single_imm got %h want 00000005", out_imm); end
    checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL single_pc got %h want 80000000", out_pc); end
    cycle();
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL single_drain valid=%b pc=%h want 0/0", out_valid, out_pc); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_pc = 32'h8000_0000; in_instr = 32'h0000_0013;
    cycle();
    in_pc = 32'h8000_0004;
    cycle();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    in_pc = 32'h8000_0008;
    cycle();
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h8000_0000) begin errors++; $display("FAIL bp_hold ready=%b pc=%h want 0/80000000", in_ready, out_pc); end
    out_ready = 1;
    cycle();
    checks++; if (out_pc !== 32'h8000_0004) begin errors++; $display("FAIL bp_order1 got %h want 80000004", out_pc); end
    cycle();
    in_valid = 0;
    checks++; if (out_pc !== 32'h8000_0008) begin errors++; $display("FAIL bp_order2 got %h want 80000008", out_pc); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_imm();
    logic [31:0] words [7] = '{32'hFE11_2E23, 32'hFE00_08E3, 32'h8000_00EF, 32'h1234_5037, 32'h0000_007F, 32'h0000_0001, 32'h0020_81B3};
    logic [31:0] imms  [7] = '{32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFF0_0000, 32'h1234_5000, 32'h0, 32'h0, 32'h0};
    logic [2:0]  fmts  [7] = '{3'd2, 3'd3, 3'd5, 3'd4, 3'd7, 3'd7, 3'd0};
    logic        ills  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1; in_pc = 32'h100 + 32'(4 * k); in_instr = words[k];
      cycle();
      in_valid = 0;
      checks++;
      if (out_fmt !== fmts[k] || out_imm !== imms[k] || out_illegal !== ills[k]) begin
        errors++;
        $display("FAIL imm_%h fmt=%0d imm=%h ill=%b want fmt=%0d imm=%h ill=%b", words[k], out_fmt, out_imm, out_illegal, fmts[k], imms[k], ills[k]);
      end
      cycle();
    end
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_pc = 32'hA000_0000; in_instr = 32'h13;
    cycle();
    in_pc = 32'hA000_0004;
    cycle();
    in_pc = 32'hDEAD_0000; flush = 1;
    cycle();
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full valid=%b ready=%b want 0/1", out_valid, in_ready); end
    in_valid = 1; in_pc = 32'hA000_0010;
    cycle();
    in_pc = 32'hDEAD_0004; flush = 1;
    cycle();
    flush = 0; in_valid = 0; out_ready = 1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop valid=%b pc=%h want 0", out_valid, out_pc); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost valid=%b pc=%h want 0", out_valid, out_pc); end
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_pc = 32'hB000_0000; in_instr = 32'h13;
    cycle();
    in_valid = 0;
    #2;
    rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin errors++; $display("FAIL async_reset valid=%b pc=%h want 0/0", out_valid, out_pc); end
    do_reset();
    out_ready = 1;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_release valid=%b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h01};
    logic [31:0] r;
    ent_t        e;
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 19) == 0;
      in_pc     = $urandom();
      in_instr  = {r[31:7], ops[$urandom_range(0, 11)]};
      if (in_instr == EBREAK) in_instr[31] = 1'b1;
      cycle();
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, out_valid, q.size() != 0); end
      checks++; if (in_ready !== (q.size() < 2 && !m_halted)) begin errors++; $display("FAIL rnd_ready n=%0d got %b", n, in_ready); end
      if (q.size() != 0) begin
        e = q[0];
        checks++;
        if (out_pc !== e.pc || out_instr !== e.instr || out_rd !== e.instr[11:7] || out_rs1 !== e.instr[19:15] || out_rs2 !== e.instr[24:20]) begin
          errors++; $display("FAIL rnd_head n=%0d pc=%h instr=%h want pc=%h instr=%h", n, out_pc, out_instr, e.pc, e.instr);
        end
        checks++;
        if (out_fmt !== ref_fmt(e.instr) || out_imm !== ref_imm(e.instr) || out_illegal !== (ref_fmt(e.instr) == 3'd7) || out_ebreak !== 1'b0) begin
          errors++; $display("FAIL rnd_decode n=%0d instr=%h fmt=%0d imm=%h ill=%b want fmt=%0d imm=%h", n, e.instr, out_fmt, out_imm, out_illegal, ref_fmt(e.instr), ref_imm(e.instr));
        end
      end else begin
        checks++;
        if ({out_pc, out_instr, out_imm, out_fmt, out_illegal, out_ebreak} !== '0) begin
          errors++; $display("FAIL rnd_idle_zero n=%0d pc=%h instr=%h imm=%h", n, out_pc, out_instr, out_imm);
        end
      end
    end
    flush = 0; in_valid = 0;
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1; in_valid = 1; in_pc = 32'hC000_0000; in_instr = EBREAK;
    cycle();
    checks++; if (out_ebreak !== 1'b1 || out_fmt !== 3'd1 || out_illegal !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_ebreak ebreak=%b fmt=%0d ill=%b halted=%b want 1/1/0/0", out_ebreak, out_fmt, out_illegal, halted);
    end
    in_pc = 32'hC000_0004; in_instr = 32'h13;
    cycle();
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_set halted=%b ready=%b want 1/0", halted, in_ready); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hC000_0004) begin errors++; $display("FAIL halt_drain valid=%b pc=%h want 1/c0000004", out_valid, out_pc); end
    in_pc = 32'hC000_0008;
    repeat (4) cycle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_sticky valid=%b ready=%b halted=%b want 0/0/1", out_valid, in_ready, halted);
    end
    flush = 1;
    cycle();
    flush = 0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flush halted=%b want 1", halted); end
    do_reset();
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL halt_clear halted=%b ready=%b want 0/1", halted, in_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_imm();
    test_flush();
    test_async_reset();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
